// File: rtl/seg_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl_pkg : shared constants for the 7-segment scan controller. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seg_scan_ctrl_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} glyphs for 0..F
  localparam logic [6:0] SEG_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_t;

endpackage

`default_nettype wire

// File: rtl/seg_scan_ctrl_hex_to_7seg.sv
// ---------------------------------------------------------------------------
// hex_to_7seg : combinational nibble to active-low segment decode. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hex_to_7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  import seg_scan_ctrl_pkg::*;

  assign seg = SEG_FONT[nibble];

endmodule

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl : multiplexed 7-seg scanner with frame-aligned load. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg_scan_ctrl #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int NUM_DIGITS   = 4
) (
  input  logic                          clock_in,
  input  logic                          reset,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [4*NUM_DIGITS-1:0]       load_data,
  input  logic                          lz_blank_en,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);
  import seg_scan_ctrl_pkg::*;

  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [31:0]             cnt;
  logic [4*NUM_DIGITS-1:0] active;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    pending;

  logic                    cnt_wrap;
  logic                    frame_wrap;
  logic                    accept;
  phase_t                  phase;
  logic                    upper_zero;
  logic                    suppress;
  logic [3:0]              nibble;
  logic [6:0]              font_seg;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic [6:0]              seg_nxt;

  assign cnt_wrap   = (cnt == 32'(SCAN_DIV - 1));
  assign frame_wrap = cnt_wrap && (digit_idx == IDX_W'(NUM_DIGITS - 1));
  assign load_ready = !pending;
  assign accept     = load_valid && !pending;
  assign dp         = 1'b1;
  assign nibble     = active[{digit_idx, 2'b00} +: 4];

  hex_to_7seg u_font (
    .nibble (nibble),
    .seg    (font_seg)
  );

  // A digit is a leading zero when it and every more significant nibble are 0
  always_comb begin
    upper_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((IDX_W'(j) >= digit_idx) && (active[4*j +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
  end

  assign suppress = lz_blank_en && (digit_idx != '0) && upper_zero;

  always_comb begin
    phase   = (cnt < 32'(BLANK_CYCLES)) ? PH_BLANK : PH_SHOW;
    an_nxt  = '1;
    seg_nxt = SEG_BLANK;
    if (phase == PH_SHOW && !suppress) begin
      an_nxt[digit_idx] = 1'b0;
      seg_nxt           = font_seg;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      cnt        <= '0;
      digit_idx  <= '0;
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      an         <= '1;
      seg        <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg        <= seg_nxt;
      frame_done <= frame_wrap;

      if (cnt_wrap) begin
        cnt       <= '0;
        digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      end else begin
        cnt <= cnt + 32'd1;
      end

      // A pending value is only ever swapped in on a frame boundary
      if (frame_wrap && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end else if (accept) begin
        shadow  <= load_data;
        pending <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl : randomized bench with a frame-level reference model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seg_scan_ctrl;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int ND = 4;

  logic        clock_in = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic        lz_blank_en = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_idx;
  logic        frame_done;

  seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .NUM_DIGITS(ND)) dut (
    .clock_in    (clock_in),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .lz_blank_en (lz_blank_en),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .digit_idx   (digit_idx),
    .frame_done  (frame_done)
  );

  always #5 clock_in = ~clock_in;

  int total = 0;
  int bad = 0;

  logic [6:0] font [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Reference model: t counts cycles since reset release
  int          t = 0;
  logic [15:0] m_active = '0;
  logic [15:0] m_shadow = '0;
  bit          m_pending = 0;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  bit          exp_fd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0d time=%0t", tag, got, exp, t, $time);
    end
  endtask

  task automatic timeout(input string tag);
    total++;
    bad++;
    $display("FAIL %s timeout t=%0d", tag, t);
  endtask

  task automatic step(input bit r, input bit v, input logic [15:0] d, input bit lz);
    int         slot, dig;
    bit         wrap, acc;
    logic [3:0] nib;
    reset       = r;
    load_valid  = v;
    load_data   = d;
    lz_blank_en = lz;
    if (r) begin
      exp_an = 4'hF; exp_seg = 7'h7F; exp_fd = 0;
      t = 0; m_active = '0; m_shadow = '0; m_pending = 0;
    end else begin
      slot = t % SD;
      dig  = (t / SD) % ND;
      wrap = (t % (SD * ND)) == (SD * ND - 1);
      nib  = 4'((m_active >> (4 * dig)) & 16'hF);
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
      if (slot >= BC && !(lz && dig > 0 && (m_active >> (4 * dig)) == 16'h0)) begin
        exp_an[dig] = 1'b0;
        exp_seg     = font[nib];
      end
      exp_fd = wrap;
      acc    = v && !m_pending;
      if (wrap && m_pending) begin
        m_active  = m_shadow;
        m_pending = 0;
      end else if (acc) begin
        m_shadow  = d;
        m_pending = 1;
      end
      t++;
    end
    @(posedge clock_in);
    @(negedge clock_in);
    check("an", 32'(an), 32'(exp_an));
    check("seg", 32'(seg), 32'(exp_seg));
    check("frame_done", 32'(frame_done), 32'(exp_fd));
    check("dp", 32'(dp), 32'd1);
    check("digit_idx", 32'(digit_idx), 32'((t / SD) % ND));
    check("load_ready", 32'(load_ready), 32'(!m_pending));
  endtask

  task automatic idle(input int n, input bit lz);
    for (int i = 0; i < n; i++) step(0, 0, 16'h0, lz);
  endtask

  task automatic wait_frame_start(input string tag, input int phase_t);
    int n = 0;
    while (!((t % (SD * ND)) == phase_t && !m_pending) && n < 200) begin
      step(0, 0, 16'h0, 0);
      n++;
    end
    if (n >= 200) timeout(tag);
  endtask

  initial begin
    bit lz_hold = 0;
    int n;

    // Reset held 3 cycles, then idle frames of zeros
    for (int i = 0; i < 3; i++) step(1, 0, 16'h0, 0);
    idle(40, 0);

    // Plain load, no blanking
    step(0, 1, 16'h12A5, 0);
    idle(70, 0);

    // Leading-zero blanking
    step(0, 1, 16'h0005, 1);
    idle(70, 1);

    // Back-to-back loads; second is held until taken
    step(0, 1, 16'h1111, 0);
    n = 0;
    while (!(m_pending && m_shadow == 16'h2222) && n < 100) begin
      step(0, 1, 16'h2222, 0);
      n++;
    end
    if (n >= 100) timeout("b2b_accept");
    idle(80, 0);

    // Load presented exactly on the frame-wrap cycle
    wait_frame_start("wrap_load", SD * ND - 1);
    step(0, 1, 16'h3C3C, 0);
    idle(80, 0);

    // Reset at digit 2, cnt 5 with a value pending
    wait_frame_start("reset_sync", 0);
    step(0, 1, 16'h7777, 0);
    while ((t % (SD * ND)) != 2 * SD + 5) step(0, 0, 16'h0, 0);
    step(1, 0, 16'h0, 0);
    idle(80, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) lz_hold = !lz_hold;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
           16'($urandom), lz_hold);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed 7-segment scan controller for the calculator display. It sequences NUM_DIGITS common-anode digits from one fast clock, using an internal clock-enable counter rather than a derived clock. Each digit slot starts with an anti-ghosting blank period. New display values arrive over a valid/ready handshake and are applied only at frame boundaries, so a frame never tears. Hex-to-segment decoding and optional leading-zero blanking are built in.

Parameters:
SCAN_DIV, 100000, clock_in cycles per digit slot (1 kHz slot rate at 100 MHz); must be >= 2
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be < SCAN_DIV
NUM_DIGITS, 4, number of digits scanned; range 2..8

Ports:
clock_in  in  1  system clock; only clock in the block
reset  in  1  synchronous, active-high reset
load_valid  in  1  new display value offered
load_ready  out  1  controller can accept a value (= no pending value)
load_data  in  4*NUM_DIGITS  hex nibbles; nibble k drives digit k (0 = rightmost)
lz_blank_en  in  1  enable leading-zero blanking
an  out  NUM_DIGITS  anodes, active-low
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low; held 1 (off)
digit_idx  out  $clog2(NUM_DIGITS)  digit currently scanned
frame_done  out  1  one-cycle pulse at each frame wrap

Behaviour:
- Reset is synchronous and active-high. The cycle after reset is sampled high, the outputs are:
  - an = all 1s, seg = 7'h7F, dp = 1, digit_idx = 0, frame_done = 0, load_ready = 1.
  - Internal state: cnt = 0, active display register = 0, shadow register = 0, pending = 0.
- cnt is 32-bit. It runs 0..SCAN_DIV-1 every cycle and wraps to 0.
- On wrap (cnt == SCAN_DIV-1):
  - digit_idx increments mod NUM_DIGITS.
  - When digit_idx == NUM_DIGITS-1 the wrap is a frame wrap.
- Slot phases:
  - BLANK while cnt < BLANK_CYCLES.
  - SHOW while cnt >= BLANK_CYCLES.
- an, seg and frame_done are registered, with one cycle of latency from the cnt/digit_idx state that produces them.
  - In BLANK: an = all 1s, seg = 7'h7F.
  - In SHOW: an[digit_idx] = 0 and all other anodes = 1, unless the digit is suppressed (see leading-zero rule).
- Leading-zero blanking (lz_blank_en = 1):
  - Digit k is suppressed if k > 0 and every nibble k..NUM_DIGITS-1 of the active register is 0.
  - A suppressed digit behaves as BLANK for its whole slot.
  - Digit 0 is never suppressed.
- Handshake:
  - load_ready = !pending.
  - On load_valid && load_ready: shadow <= load_data, pending <= 1.
  - load_data is ignored when ready = 0. load_valid may be held.
- Frame wrap:
  - frame_done pulses once.
  - If pending: active <= shadow, pending <= 0, so load_ready = 1 the next cycle.
- Simultaneous accept and frame wrap with pending = 0: the value is captured into shadow but not applied. It is applied at the next frame wrap.
- With pending = 1 at a frame wrap, no accept is possible that cycle.
- Reset mid-slot or mid-frame: all state returns to reset values on the next edge, and any pending value is discarded.
- Segment decode is the standard hex font, for example: 0 = 40, 1 = 79, 2 = 24, 5 = 12, 8 = 00, A = 08, F = 0E (hex, active-low).

Decomposition:
- Shared package holds:
  - SEG_BLANK = 7'h7F.
  - The 16-entry hex segment font constants.
  - The slot-phase enum {PH_BLANK, PH_SHOW}.
- One natural sub-module: hex_to_7seg. It is a combinational nibble-to-seg decode, reusable by other calculator blocks.
- The counter, handshake and scan FSM stay in seg_scan_ctrl.

Test Plan:
All scenarios use SCAN_DIV = 8, BLANK_CYCLES = 2, NUM_DIGITS = 4.
1. Hold reset 3 cycles then release, no load -> an = 4'hF and seg = 7'h7F during reset. After release, each slot shows an = 1110/1101/1011/0111 for 6 of 8 cycles, all digits seg = 40; load_ready = 1.
2. Load 16'h12A5 with lz_blank_en = 0 -> accepted in 1 cycle. load_ready = 0 until the next frame_done, then 1. Next frame shows digit0 = 12, digit1 = 08, digit2 = 24, digit3 = 79, each with its anode low on cnt 2..7 (+1 cycle latency).
3. Load 16'h0005 with lz_blank_en = 1 -> after the frame wrap, slots 1..3 keep an = 4'hF for all 8 cycles; slot 0 shows seg = 12 with an = 4'b1110.
4. Two back-to-back loads (16'h1111, then 16'h2222 with valid held) -> the second stalls with ready = 0 until the frame wrap applies 1111. The second is then accepted and displayed one frame later.
5. Load asserted exactly on the frame-wrap cycle with pending = 0 -> frame_done pulses, the old value is kept, and the new value is displayed only after the following frame_done.
6. Assert reset while digit_idx = 2 and cnt = 5 with a value pending -> next cycle: an = 4'hF, digit_idx = 0, load_ready = 1. The pending value is never displayed.
